message_checker: RTL and testbench

//  Downstream stage of the key-search controller in the RC4 brute-force cracker.

---
 rtl/message_checker.sv | 102 ++++++++++
 tb/tb_message_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/message_checker.sv
// message_checker: validates the decrypted byte stream for one candidate key.
// A legal byte is a lowercase letter or a space. Legal bytes are written to the
// result RAM in order. The first illegal byte stops the check and its position
// is recorded in fail_index.
module message_checker #(
  parameter int unsigned MSG_LEN    = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter logic [7:0]  LO_CHAR    = 8'h61,
  parameter logic [7:0]  HI_CHAR    = 8'h7A,
  parameter logic [7:0]  SPACE_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              success,
  output logic              failure,
  output logic              dout_wren,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [7:0]        dout_data,
  output logic [ADDR_W-1:0] fail_index
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic              legal;
  logic              xfer;

  // Byte legality and handshake qualification
  always_comb begin
    legal      = ((byte_data >= LO_CHAR) && (byte_data <= HI_CHAR)) ||
                 (byte_data == SPACE_CHAR);
    byte_ready = (state == ST_CHECK) && run;
    xfer       = byte_valid && byte_ready;
  end

  // Checker FSM with registered status and RAM-write outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      success    <= 1'b0;
      failure    <= 1'b0;
      dout_wren  <= 1'b0;
      dout_addr  <= '0;
      dout_data  <= '0;
      fail_index <= '0;
    end else begin
      dout_wren <= 1'b0;
      if (!run) begin
        // run low overrides everything; dout_addr/dout_data keep their last
        // values since dout_wren qualifies them
        state      <= ST_IDLE;
        count      <= '0;
        success    <= 1'b0;
        failure    <= 1'b0;
        fail_index <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_CHECK;
            count <= '0;
          end
          ST_CHECK: begin
            if (xfer) begin
              if (legal) begin
                dout_wren <= 1'b1;
                dout_addr <= count;
                dout_data <= byte_data;
                if (count == LAST_IDX) begin
                  state   <= ST_PASS;
                  success <= 1'b1;
                end else begin
                  count <= count + 1'b1;
                end
              end else begin
                fail_index <= count;
                failure    <= 1'b1;
                state      <= ST_FAIL;
              end
            end
          end
          ST_PASS: success <= 1'b1;
          ST_FAIL: failure <= 1'b1;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_message_checker.sv
// Directed bench for message_checker: full passes, mid-stream failure,
// legality boundaries, gapped valid, run-drop restart and async reset.
module tb_message_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       success;
  logic       failure;
  logic       dout_wren;
  logic [4:0] dout_addr;
  logic [7:0] dout_data;
  logic [4:0] fail_index;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  message_checker #(
    .MSG_LEN(32),
    .ADDR_W (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .success   (success),
    .failure   (failure),
    .dout_wren (dout_wren),
    .dout_addr (dout_addr),
    .dout_data (dout_data),
    .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte for one cycle, then check the registered write result.
  task automatic xfer(input logic [7:0] b, input logic exp_wr, input int unsigned idx);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("wren", 32'(dout_wren), 32'(exp_wr));
    if (exp_wr) begin
      chk("addr", 32'(dout_addr), idx);
      chk("data", 32'(dout_data), 32'(b));
    end
  endtask

  // Drop run for a cycle, then raise it and wait the start latency.
  task automatic start_run();
    run        = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_success", 32'(success), 32'd0);
    chk("clr_failure", 32'(failure), 32'd0);
    run = 1'b1;
    @(posedge clk); #1;
    chk("ready_start", 32'(byte_ready), 32'd1);
  endtask

  logic [7:0]  msg [32];
  logic [7:0]  bnd [6];
  string       s;
  int unsigned ntx;
  int unsigned cyc;

  initial begin
    s = "attack at dawn";
    for (int i = 0; i < 32; i++) msg[i] = (i < s.len()) ? s[i] : 8'h61;
    bnd[0] = 8'h60; bnd[1] = 8'h7B; bnd[2] = 8'h1F;
    bnd[3] = 8'h61; bnd[4] = 8'h7A; bnd[5] = 8'h20;

    reset = 1'b0; run = 1'b0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_failure", 32'(failure), 32'd0);
    chk("rst_wren", 32'(dout_wren), 32'd0);
    chk("rst_addr", 32'(dout_addr), 32'd0);
    chk("rst_failidx", 32'(fail_index), 32'd0);
    reset = 1'b1;

    // 1) full legal message
    start_run();
    for (int i = 0; i < 32; i++) begin
      xfer(msg[i], 1'b1, i);
      chk("t1_success", 32'(success), (i == 31) ? 32'd1 : 32'd0);
      chk("t1_failure", 32'(failure), 32'd0);
    end
    byte_valid = 1'b1; byte_data = 8'h61;
    #1 chk("t1_ready_pass", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    chk("t1_no_wren", 32'(dout_wren), 32'd0);
    chk("t1_hold", 32'(success), 32'd1);
    byte_valid = 1'b0;

    // 2) illegal 'A' at index 5
    start_run();
    for (int i = 0; i < 5; i++) xfer(8'h61, 1'b1, i);
    xfer(8'h41, 1'b0, 5);
    chk("t2_failure", 32'(failure), 32'd1);
    chk("t2_success", 32'(success), 32'd0);
    chk("t2_failidx", 32'(fail_index), 32'd5);
    byte_valid = 1'b1; byte_data = 8'h61;
    #1 chk("t2_ready_fail", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    chk("t2_no_wren", 32'(dout_wren), 32'd0);
    chk("t2_hold", 32'(failure), 32'd1);

    // 5) from FAIL: run low one cycle with valid high, then a fresh pass
    run = 1'b0;
    #1 chk("t5_ready_runlow", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    chk("t5_no_wren", 32'(dout_wren), 32'd0);
    chk("t5_failure_clr", 32'(failure), 32'd0);
    chk("t5_failidx_clr", 32'(fail_index), 32'd0);
    byte_valid = 1'b0;
    run = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) xfer(8'h7A - 8'(i % 26), 1'b1, i);
    chk("t5_success", 32'(success), 32'd1);
    chk("t5_failure", 32'(failure), 32'd0);

    // 3) legality boundaries
    for (int k = 0; k < 3; k++) begin
      start_run();
      xfer(bnd[k], 1'b0, 0);
      chk("t3_fail", 32'(failure), 32'd1);
      chk("t3_failidx", 32'(fail_index), 32'd0);
    end
    for (int k = 3; k < 6; k++) begin
      start_run();
      for (int i = 0; i < 32; i++) xfer(bnd[k], 1'b1, i);
      chk("t3_pass", 32'(success), 32'd1);
      chk("t3_nofail", 32'(failure), 32'd0);
    end

    // 4) random gaps on byte_valid
    start_run();
    ntx = 0; cyc = 0;
    while (ntx < 32 && cyc < 500) begin
      byte_valid = 1'($urandom_range(0, 1));
      byte_data  = 8'h61 + 8'($urandom_range(0, 25));
      @(posedge clk); #1;
      chk("t4_wren", 32'(dout_wren), 32'(byte_valid));
      if (byte_valid) begin
        chk("t4_addr", 32'(dout_addr), ntx);
        ntx++;
      end
      chk("t4_success", 32'(success), (ntx == 32) ? 32'd1 : 32'd0);
      cyc++;
    end
    byte_valid = 1'b0;
    chk("t4_transfers", ntx, 32'd32);

    // 6) async reset at byte 17
    start_run();
    for (int i = 0; i < 17; i++) xfer(8'h20, 1'b1, i);
    byte_valid = 1'b1; byte_data = 8'h61;
    #2 reset = 1'b0;
    #1;
    chk("t6_ready", 32'(byte_ready), 32'd0);
    chk("t6_wren", 32'(dout_wren), 32'd0);
    chk("t6_addr", 32'(dout_addr), 32'd0);
    chk("t6_data", 32'(dout_data), 32'd0);
    chk("t6_success", 32'(success), 32'd0);
    chk("t6_failure", 32'(failure), 32'd0);
    byte_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready_restart", 32'(byte_ready), 32'd1);
    xfer(8'h62, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
